// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: latches a 32-bit word and pages its two 16-bit halves
// onto four active-low seven-segment displays.
// It alternates the halves on a PAGE_TICKS interval and supports hold and
// leading-zero blanking.
//
// Ports:
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   load         latch data_in and restart on the low page
//   data_in[31:0] word to display
//   hold         freeze page counter and page state (load still accepted)
//   blank_lz     enable leading-zero blanking on hex3..hex1
//   load_ack     one-cycle pulse per accepted load
//   page         0 = val[15:0] shown, 1 = val[31:16] shown
//   hex0..hex3   active-low segments, hex0 = least significant nibble

// Nibble to active-low segment pattern (bit0 = segment a ... bit6 = segment g).
module hex_to_7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    unique case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
    endcase
  end

endmodule

module seg_display_ctrl #(
  parameter int unsigned PAGE_TICKS = 50_000_000,
  parameter int unsigned CW         = 26
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        hold,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic        page,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam logic [CW-1:0] TERM  = CW'(PAGE_TICKS - 1);
  localparam logic [6:0]    BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   val, val_nxt;
  logic          ack_nxt;
  logic          page_nxt;
  logic [15:0]   half;
  logic [6:0]    seg [4];
  logic [6:0]    hex_nxt [4];
  logic [3:0]    lead_zero;

  // State, counter, latched value and all outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      val      <= '0;
      load_ack <= 1'b0;
      page     <= 1'b0;
      hex0     <= BLANK;
      hex1     <= BLANK;
      hex2     <= BLANK;
      hex3     <= BLANK;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      val      <= val_nxt;
      load_ack <= ack_nxt;
      page     <= page_nxt;
      hex0     <= hex_nxt[0];
      hex1     <= hex_nxt[1];
      hex2     <= hex_nxt[2];
      hex3     <= hex_nxt[3];
    end
  end

  // Next-state: load beats terminal count, terminal count beats hold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    val_nxt   = val;
    ack_nxt   = 1'b0;
    if (load) begin
      val_nxt   = data_in;
      state_nxt = SHOW_LO;
      cnt_nxt   = '0;
      ack_nxt   = 1'b1;
    end else begin
      unique case (state)
        IDLE: cnt_nxt = '0;
        SHOW_LO: begin
          // A value with an empty high half never pages.
          if (val[31:16] == 16'd0) begin
            cnt_nxt = '0;
          end else if (cnt == TERM) begin
            state_nxt = SHOW_HI;
            cnt_nxt   = '0;
          end else if (!hold) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SHOW_HI: begin
          if (cnt == TERM) begin
            state_nxt = SHOW_LO;
            cnt_nxt   = '0;
          end else if (!hold) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    page_nxt = (state_nxt == SHOW_HI);
  end

  // Half currently on show, decoded one cycle behind the state.
  assign half = (state == SHOW_HI) ? val[31:16] : val[15:0];

  for (genvar k = 0; k < 4; k++) begin : g_dig
    hex_to_7 u_hex (
      .nibble (half[4*k +: 4]),
      .seg_c  (seg[k])
    );
  end

  // lead_zero[k]: nibble k and every nibble above it are zero.
  assign lead_zero[3] = (half[15:12] == 4'd0);
  assign lead_zero[2] = (half[15:8]  == 8'd0);
  assign lead_zero[1] = (half[15:4]  == 12'd0);
  assign lead_zero[0] = 1'b0;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hex_nxt[k] = seg[k];
      if (state == IDLE || (blank_lz && lead_zero[k])) begin
        hex_nxt[k] = BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (PAGE_TICKS = 4, CW = 3):
// directed scenarios followed by random traffic, all compared every cycle
// against a behavioural model of the display.
module tb_seg_display_ctrl;

  localparam int unsigned PT = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clock;
  logic        clear;
  logic        load;
  logic [31:0] data_in;
  logic        hold;
  logic        blank_lz;
  logic        load_ack;
  logic        page;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a flag for "something loaded", the word, which half
  // is up, how many cycles that half has been up, and the display.
  bit          m_active;
  logic [31:0] m_val;
  bit          m_page;
  int          m_age;
  bit          m_ack;
  logic [6:0]  m_hex [4];

  seg_display_ctrl #(.PAGE_TICKS(PT), .CW(3)) dut (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .data_in  (data_in),
    .hold     (hold),
    .blank_lz (blank_lz),
    .load_ack (load_ack),
    .page     (page),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Displayed digit k of a 16-bit half, with optional leading-zero blanking.
  function automatic logic [6:0] digit(input logic [15:0] h, input int k, input bit bl);
    logic [15:0] above;
    logic [3:0]  nib;
    above = h >> (4 * k);
    nib   = 4'(above);
    if (bl && k > 0 && above == 16'd0) return 7'h7F;
    return SEG_TAB[nib];
  endfunction

  // One clock edge: advance the model from the inputs held across the edge,
  // then compare every output.
  task automatic cycle();
    logic [15:0] h;
    @(posedge clock);
    #1;
    h = m_page ? m_val[31:16] : m_val[15:0];
    if (clear) begin
      m_active = 0; m_val = '0; m_page = 0; m_age = 0; m_ack = 0;
      for (int k = 0; k < 4; k++) m_hex[k] = 7'h7F;
    end else begin
      for (int k = 0; k < 4; k++) m_hex[k] = m_active ? digit(h, k, blank_lz) : 7'h7F;
      m_ack = load;
      if (load) begin
        m_val = data_in; m_active = 1; m_page = 0; m_age = 0;
      end else if (m_active) begin
        if (!m_page && m_val[31:16] == 16'd0) m_age = 0;
        else if (m_age == int'(PT) - 1) begin
          m_page = !m_page;
          m_age  = 0;
        end else if (!hold) m_age++;
      end
    end
    chk("page", {31'd0, page}, {31'd0, m_page});
    chk("load_ack", {31'd0, load_ack}, {31'd0, m_ack});
    chk("hex0", {25'd0, hex0}, {25'd0, m_hex[0]});
    chk("hex1", {25'd0, hex1}, {25'd0, m_hex[1]});
    chk("hex2", {25'd0, hex2}, {25'd0, m_hex[2]});
    chk("hex3", {25'd0, hex3}, {25'd0, m_hex[3]});
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_h3"}, {25'd0, hex3}, {25'd0, e3});
    chk({tag, "_h2"}, {25'd0, hex2}, {25'd0, e2});
    chk({tag, "_h1"}, {25'd0, hex1}, {25'd0, e1});
    chk({tag, "_h0"}, {25'd0, hex0}, {25'd0, e0});
  endtask

  initial begin
    m_active = 0; m_val = '0; m_page = 0; m_age = 0; m_ack = 0;
    for (int k = 0; k < 4; k++) m_hex[k] = 7'h7F;
    clear = 1'b1; load = 1'b0; data_in = '0; hold = 1'b0; blank_lz = 1'b0;

    // Reset, then idle with no load.
    cycle();
    cycle();
    clear = 1'b0;
    chk_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    repeat (20) cycle();
    chk_hex("idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Two-page value.
    load = 1'b1; data_in = 32'h1234_ABCD;
    cycle();
    chk("ack_pulse", {31'd0, load_ack}, 32'd1);
    load = 1'b0;
    cycle();
    chk_hex("lo_page", 7'h08, 7'h03, 7'h46, 7'h21);
    cycle();
    cycle();
    cycle();
    chk("page_hi", {31'd0, page}, 32'd1);
    cycle();
    chk_hex("hi_page", 7'h79, 7'h24, 7'h30, 7'h19);

    // Hold in the high page, then let the remaining count run out.
    hold = 1'b1;
    repeat (10) begin
      cycle();
      chk("hold_page", {31'd0, page}, 32'd1);
    end
    hold = 1'b0;
    cycle();
    cycle();
    chk("hold_resume", {31'd0, page}, 32'd1);
    cycle();
    chk("hold_switch", {31'd0, page}, 32'd0);

    // Single page with leading-zero blanking.
    blank_lz = 1'b1; load = 1'b1; data_in = 32'h0000_0050;
    cycle();
    load = 1'b0;
    cycle();
    chk_hex("blank", 7'h7F, 7'h7F, 7'h12, 7'h40);
    repeat (20) begin
      cycle();
      chk("single_page", {31'd0, page}, 32'd0);
    end
    blank_lz = 1'b0;
    cycle();
    chk_hex("unblank", 7'h40, 7'h40, 7'h12, 7'h40);

    // Load on the terminal-count cycle of the low page.
    load = 1'b1; data_in = 32'h1234_ABCD;
    cycle();
    load = 1'b0;
    repeat (3) cycle();
    load = 1'b1; data_in = 32'hFFFF_0000;
    cycle();
    chk("prio_page", {31'd0, page}, 32'd0);
    chk("prio_ack", {31'd0, load_ack}, 32'd1);
    load = 1'b0;
    cycle();
    chk_hex("prio_hex", 7'h40, 7'h40, 7'h40, 7'h40);
    repeat (3) cycle();
    chk("prio_full_page", {31'd0, page}, 32'd1);

    // Clear together with load in the high page.
    clear = 1'b1; load = 1'b1; data_in = 32'h5555_AAAA;
    cycle();
    chk_hex("clr", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("clr_page", {31'd0, page}, 32'd0);
    chk("clr_ack", {31'd0, load_ack}, 32'd0);
    clear = 1'b0; load = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 11) == 0);
      clear = ($urandom_range(0, 79) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
      data_in = $urandom;
      case ($urandom_range(0, 5))
        0: data_in[31:16] = 16'd0;
        1: data_in[31:8]  = 24'd0;
        2: data_in[15:4]  = 12'd0;
        default: ;
      endcase
      cycle();
    end
    load = 1'b0; clear = 1'b0; hold = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
